// File: rtl/chunked_serial_adder_if.sv
// Operand/result bundle for chunked_serial_adder: the requester drives the
// operation request and operands, the adder returns status and the result.
interface chunked_serial_adder_if #(
   parameter int WIDTH = 6
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: latches operands, adds CHUNK bits per cycle over
// N = WIDTH/CHUNK cycles, then publishes sum/cout/overflow with a done pulse.
//
// state | meaning
// IDLE  | waiting for start; last result held on outputs
// RUN   | adding chunk idx of the latched operands, busy high
// DONE  | new result valid for one cycle; start here chains the next op
module chunked_serial_adder #(
   parameter int WIDTH = 6,
   parameter int CHUNK = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   chunked_serial_adder_if.slave bus
);
   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0] op_a, op_b, work, work_next;
   logic [WIDTH-1:0] sum_q;
   logic             carry, cout_q, ovf_q;
   logic [IDX_W-1:0] idx;
   logic [CHUNK-1:0] chunk_a, chunk_b;
   logic [CHUNK:0]   chunk_sum;
   logic             msb_carry_in, last, accept, busy, done;

   always_comb begin
      chunk_a   = op_a[idx*CHUNK +: CHUNK];
      chunk_b   = op_b[idx*CHUNK +: CHUNK];
      chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
      work_next = work;
      work_next[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      // sum bit = a ^ b ^ carry_in, so the carry into the top bit is recovered
      // from inside the chunk rather than taken from the chunk boundary.
      msb_carry_in = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_sum[CHUNK-1];
      last         = (idx == LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_a   <= '0;
         op_b   <= '0;
         carry  <= 1'b0;
         work   <= '0;
         idx    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         op_a  <= bus.a;
         op_b  <= bus.b;
         carry <= bus.cin;
         work  <= '0;
         idx   <= '0;
      end else if (state == RUN) begin
         work  <= work_next;
         carry <= chunk_sum[CHUNK];
         if (last) begin
            sum_q  <= work_next;
            cout_q <= chunk_sum[CHUNK];
            ovf_q  <= msb_carry_in ^ chunk_sum[CHUNK];
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench: WIDTH=6/CHUNK=2 instance for directed and random
// operations, plus WIDTH=8 instances with CHUNK=1,2,4,8 for latency sweep.
module tb_chunked_serial_adder;
   localparam int W = 6;
   localparam int N = 3;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] prev_sum;
   logic        prev_cout, prev_ovf;

   always #5 clk = ~clk;

   chunked_serial_adder_if #(.WIDTH(W)) bif();
   chunked_serial_adder #(.WIDTH(W), .CHUNK(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   logic       s_start, s_cin;
   logic [7:0] s_a, s_b;
   logic [3:0] sw_done, sw_cout, sw_ovf;
   logic [7:0] sw_sum [4];

   for (genvar g = 0; g < 4; g++) begin : g_sw
      chunked_serial_adder_if #(.WIDTH(8)) sif();
      assign sif.start = s_start;
      assign sif.a     = s_a;
      assign sif.b     = s_b;
      assign sif.cin   = s_cin;
      chunked_serial_adder #(.WIDTH(8), .CHUNK(1 << g)) u_add (
         .clk   (clk),
         .reset (reset),
         .bus   (sif)
      );
      assign sw_done[g] = sif.done;
      assign sw_sum[g]  = sif.sum;
      assign sw_cout[g] = sif.cout;
      assign sw_ovf[g]  = sif.overflow;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed overflow as an out-of-range result.
   function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, output logic [31:0] s,
                                 output logic co, output logic ov);
      longint ua, ub, t, half, sa, sb, st;
      ua   = longint'(a);
      ub   = longint'(b);
      t    = ua + ub + longint'(c);
      s    = 32'(t % (longint'(1) << w));
      co   = (t >= (longint'(1) << w));
      half = longint'(1) << (w - 1);
      sa   = (ua >= half) ? ua - 2 * half : ua;
      sb   = (ub >= half) ? ub - 2 * half : ub;
      st   = sa + sb + longint'(c);
      ov   = (st >= half) || (st < -half);
   endfunction

   task automatic check_result(input string tag, input logic [31:0] es, input logic eco, input logic eov);
      check({tag, "_done"}, 32'(bif.done), 32'd1);
      check({tag, "_busy"}, 32'(bif.busy), 32'd0);
      check({tag, "_sum"},  32'(bif.sum), es);
      check({tag, "_cout"}, 32'(bif.cout), 32'(eco));
      check({tag, "_ovf"},  32'(bif.overflow), 32'(eov));
      prev_sum  = es;
      prev_cout = eco;
      prev_ovf  = eov;
   endtask

   task automatic run_checks(input string tag);
      check({tag, "_busy_run"}, 32'(bif.busy), 32'd1);
      check({tag, "_done_run"}, 32'(bif.done), 32'd0);
      check({tag, "_sum_hold"}, 32'(bif.sum), prev_sum);
      check({tag, "_cout_hold"}, 32'(bif.cout), 32'(prev_cout));
   endtask

   // mode 1: restart with a=1,b=1 on the 2nd RUN cycle (must be ignored).
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input int mode);
      logic [31:0] es;
      logic        eco, eov;
      model(W, 32'(a), 32'(b), c, es, eco, eov);
      @(negedge clk);
      bif.start = 1'b1; bif.a = a; bif.b = b; bif.cin = c;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         if (k == 0) bif.start = 1'b0;
         run_checks(tag);
         bif.a   = W'($urandom);
         bif.b   = W'($urandom);
         bif.cin = 1'($urandom);
         if (mode == 1 && k == 1) begin
            bif.start = 1'b1; bif.a = 1; bif.b = 1;
         end
         if (mode == 1 && k == 2) bif.start = 1'b0;
      end
      @(negedge clk);
      check_result(tag, es, eco, eov);
      @(negedge clk);
      check({tag, "_single_pulse"}, 32'(bif.done), 32'd0);
      check({tag, "_idle"}, 32'(bif.busy), 32'd0);
   endtask

   task automatic back_to_back();
      logic [W-1:0] oa [5];
      logic [W-1:0] ob [5];
      logic         oc [5];
      logic [31:0]  es;
      logic         eco, eov;
      for (int i = 0; i < 5; i++) begin
         oa[i] = W'($urandom); ob[i] = W'($urandom); oc[i] = 1'($urandom);
      end
      @(negedge clk);
      bif.start = 1'b1; bif.a = oa[0]; bif.b = ob[0]; bif.cin = oc[0];
      for (int i = 0; i < 4; i++) begin
         model(W, 32'(oa[i]), 32'(ob[i]), oc[i], es, eco, eov);
         for (int k = 0; k < N; k++) begin
            @(negedge clk);
            run_checks("b2b");
         end
         @(negedge clk);
         check_result("b2b", es, eco, eov);
         if (i < 3) begin
            bif.a = oa[i+1]; bif.b = ob[i+1]; bif.cin = oc[i+1];
         end else begin
            bif.start = 1'b0;
         end
      end
      @(negedge clk);
      check("b2b_end_done", 32'(bif.done), 32'd0);
   endtask

   task automatic sweep_op();
      logic [31:0] es;
      logic        eco, eov;
      int          lat [4];
      s_a = 8'($urandom); s_b = 8'($urandom); s_cin = 1'($urandom);
      model(8, 32'(s_a), 32'(s_b), s_cin, es, eco, eov);
      for (int g = 0; g < 4; g++) lat[g] = -1;
      s_start = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         s_start = 1'b0;
         s_a = 8'($urandom); s_b = 8'($urandom); s_cin = 1'($urandom);
         for (int g = 0; g < 4; g++) begin
            if (sw_done[g] && lat[g] < 0) begin
               lat[g] = cyc;
               check("sw_sum",  32'(sw_sum[g]), es);
               check("sw_cout", 32'(sw_cout[g]), 32'(eco));
               check("sw_ovf",  32'(sw_ovf[g]), 32'(eov));
            end
         end
      end
      for (int g = 0; g < 4; g++) check("sw_latency", 32'(lat[g]), 32'(8 >> g));
   endtask

   initial begin
      reset = 1'b1;
      bif.start = 1'b0; bif.a = '0; bif.b = '0; bif.cin = 1'b0;
      s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0;
      prev_sum = 0; prev_cout = 1'b0; prev_ovf = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bif.busy), 32'd0);
      check("rst_done", 32'(bif.done), 32'd0);
      check("rst_sum",  32'(bif.sum), 32'd0);
      check("rst_cout", 32'(bif.cout), 32'd0);
      check("rst_ovf",  32'(bif.overflow), 32'd0);
      reset = 1'b0;

      run_op("basic", 6'd3, 6'd11, 1'b0, 0);
      check("basic_const", prev_sum, 32'b001110);
      run_op("wrap", 6'd63, 6'd1, 1'b0, 0);
      check("wrap_const", prev_sum, 32'd0);
      run_op("sovf", 6'd31, 6'd1, 1'b0, 0);
      check("sovf_const", prev_sum, 32'b100000);
      run_op("cin", 6'd0, 6'd0, 1'b1, 0);
      check("cin_const", prev_sum, 32'd1);
      run_op("ignore", 6'd45, 6'd27, 1'b1, 1);

      back_to_back();

      // Abort on the 2nd RUN cycle.
      @(negedge clk);
      bif.start = 1'b1; bif.a = 6'd20; bif.b = 6'd20; bif.cin = 1'b0;
      @(negedge clk);
      bif.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 32'(bif.busy), 32'd0);
      check("abort_done", 32'(bif.done), 32'd0);
      check("abort_sum",  32'(bif.sum), 32'd0);
      check("abort_cout", 32'(bif.cout), 32'd0);
      check("abort_ovf",  32'(bif.overflow), 32'd0);
      prev_sum = 0; prev_cout = 1'b0; prev_ovf = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("abort_no_done", 32'(bif.done), 32'd0);
      end
      run_op("post_abort", 6'd5, 6'd6, 1'b0, 0);
      check("post_abort_const", prev_sum, 32'b001011);

      // Reset wins over start on the same edge.
      @(negedge clk);
      reset = 1'b1; bif.start = 1'b1;
      @(negedge clk);
      reset = 1'b0; bif.start = 1'b0;
      check("rst_prio_busy", 32'(bif.busy), 32'd0);
      prev_sum = 0; prev_cout = 1'b0; prev_ovf = 1'b0;

      for (int i = 0; i < 20; i++)
         run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 0);

      for (int i = 0; i < 12; i++) sweep_op();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
